// File: rtl/dma_port_model.sv
// dma_port_model: paced read-port beat source from preloadable buffers plus write-port capture buffers with registered dump readback
module dma_port_model #(
  parameter int DATA_W = 16,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter int RD_DEPTH = 256,
  parameter int WR_DEPTH = 256,
  parameter int GAP = 2,
  parameter int WRAP = 0,
  localparam int RAW = $clog2(RD_DEPTH),
  localparam int WAW = $clog2(WR_DEPTH),
  localparam int RPW = RD_PORTS > 1 ? $clog2(RD_PORTS) : 1,
  localparam int WPW = WR_PORTS > 1 ? $clog2(WR_PORTS) : 1,
  localparam int PHW = GAP > 0 ? $clog2(GAP + 1) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          rewind,
  input  logic [RD_PORTS-1:0]           rd_en,
  input  logic [RD_PORTS*(RAW+1)-1:0]   rd_len,
  output logic [RD_PORTS-1:0]           rd_we,
  output logic [RD_PORTS*DATA_W-1:0]    rd_data,
  output logic [RD_PORTS-1:0]           rd_done,
  input  logic [WR_PORTS-1:0]           wr_en,
  output logic [WR_PORTS-1:0]           wr_re,
  input  logic [WR_PORTS*DATA_W-1:0]    wr_data,
  input  logic [WR_PORTS-1:0]           wr_valid,
  output logic [WR_PORTS*(WAW+1)-1:0]   wr_count,
  output logic [WR_PORTS-1:0]           wr_ovf,
  input  logic                          load_we,
  input  logic [RPW-1:0]                load_port,
  input  logic [RAW-1:0]                load_addr,
  input  logic [DATA_W-1:0]             load_data,
  input  logic [WPW-1:0]                dump_port,
  input  logic [WAW-1:0]                dump_addr,
  output logic [DATA_W-1:0]             dump_data
);
  logic [WR_PORTS*DATA_W-1:0] rq;
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [DATA_W-1:0] mem [RD_DEPTH];
    logic [PHW-1:0] ph;
    logic [RAW:0] ptr, len;
    logic [DATA_W-1:0] dq;
    logic we, done, act, slot, beat;
    assign len = rd_len[i*(RAW+1) +: RAW+1];
    assign act = enable & rd_en[i];
    assign slot = act && ph == PHW'(GAP);
    assign beat = slot && ptr < len;
    always_ff @(posedge clk)
      if (load_we && load_port == RPW'(i)) mem[load_addr] <= load_data;
    always_ff @(posedge clk)
      if (!rst) begin
        ph <= '0;
        ptr <= '0;
        we <= 1'b0;
        done <= 1'b0;
        dq <= '0;
      end else if (rewind) begin
        ph <= '0;
        ptr <= '0;
        we <= 1'b0;
        done <= 1'b0;
      end else begin
        ph <= act && !slot ? ph + 1'b1 : '0;
        we <= beat;
        if (beat) begin
          dq <= mem[ptr[RAW-1:0]];
          ptr <= WRAP != 0 && ptr == len - 1'b1 ? '0 : ptr + 1'b1;
        end
        if (slot && !beat && WRAP == 0) done <= 1'b1;
      end
    assign rd_we[i] = we;
    assign rd_done[i] = done;
    assign rd_data[i*DATA_W +: DATA_W] = dq;
  end
  for (genvar i = 0; i < WR_PORTS; i++) begin : g_wr
    logic [DATA_W-1:0] mem [WR_DEPTH];
    logic [PHW-1:0] ph;
    logic [WAW:0] cnt;
    logic re, ovf, act, slot, room;
    assign act = enable & wr_en[i];
    assign slot = act && ph == PHW'(GAP);
    assign room = cnt < (WAW+1)'(WR_DEPTH);
    always_ff @(posedge clk)
      if (rst && !rewind && wr_valid[i] && room) mem[cnt[WAW-1:0]] <= wr_data[i*DATA_W +: DATA_W];
    always_ff @(posedge clk)
      if (!rst || rewind) begin
        ph <= '0;
        re <= 1'b0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        ph <= act && !slot ? ph + 1'b1 : '0;
        re <= slot;
        if (wr_valid[i] && room) cnt <= cnt + 1'b1;
        if (wr_valid[i] && !room) ovf <= 1'b1;
      end
    assign wr_re[i] = re;
    assign wr_ovf[i] = ovf;
    assign wr_count[i*(WAW+1) +: WAW+1] = cnt;
    assign rq[i*DATA_W +: DATA_W] = mem[dump_addr];
  end
  always_ff @(posedge clk)
    dump_data <= rst ? rq[dump_port*DATA_W +: DATA_W] : '0;
endmodule
